decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 Ports: clk input 1, the single clock; rst input 1, reset; the reset is synchronous and active-high.
REQ-004 Ports: in_valid input 1; in_ready output 1; in_instr input 32; in_pc input XLEN; flush input 1, kills the held instruction.
REQ-005 Ports: out_valid output 1; out_ready input 1; out_pc output XLEN; rs1, rs2, rd output 5 each; imm output XLEN, sign-extended.
REQ-006 Ports: alu_func output 4; op1_sel output 1 (0 rs1, 1 pc); op2_sel output 2 (00 rs2, 01 imm); wb_sel output 2 (00 none, 01 alu, 10 mem, 11 pc+4).
REQ-007 Ports: reg_write, mem_read, mem_write, illegal output 1 each; br_type output 3 (funct3 of the branch); is_branch, is_jal, is_jalr output 1 each.
REQ-008 Ports: eq, lt, ltu input 1 each, compare flags for the held instruction; pc_sel output 2 (00 pc+4, 01 pc+imm, 10 (rs1+imm)&~1).
REQ-009 Port: illegal_cnt output CNT_W.

Function
REQ-010 The block SHALL be a one-entry registered decode stage; out_* fields SHALL be registered copies of the decode of the accepted instruction.
REQ-011 in_ready SHALL equal (!out_valid || out_ready) && !flush.
REQ-012 A transfer SHALL occur when in_valid && in_ready; the decoded fields SHALL appear with out_valid=1 on the next cycle (latency 1).
REQ-013 When out_valid && !out_ready, every out_* field SHALL hold stable.
REQ-014 When out_ready=1 and no transfer occurs, out_valid SHALL go to 0 on the next cycle.
REQ-015 flush=1 SHALL clear out_valid on the next cycle and SHALL block any transfer that cycle; flush has priority over out_ready.
REQ-016 The block SHALL decode these RV32I opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-017 alu_func codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASS_B 1010.
REQ-018 R-type: op2_sel=00, wb_sel=01, reg_write=1. SUB/SRA SHALL require funct7=0100000; all other R-type ops SHALL require funct7=0000000.
REQ-019 I-ALU: op2_sel=01, wb_sel=01, reg_write=1. The shamt field SHALL be bits [24:20] for XLEN=32 and [25:20] for XLEN=64. SRAI SHALL require instr[30]=1.
REQ-020 LOAD: ADD, op2_sel=01, mem_read=1, wb_sel=10, reg_write=1. STORE: ADD, op2_sel=01, mem_write=1, reg_write=0, S-immediate.
REQ-021 BRANCH: is_branch=1, B-immediate, reg_write=0. funct3 010 and 011 SHALL be illegal.
REQ-022 JAL: J-immediate, wb_sel=11, reg_write=1. JALR: I-immediate, wb_sel=11, reg_write=1; funct3 other than 000 SHALL be illegal.
REQ-023 LUI: U-immediate, PASS_B, op2_sel=01, wb_sel=01. AUIPC: op1_sel=1, op2_sel=01, ADD, wb_sel=01.
REQ-024 All immediates SHALL be sign-extended from the instruction's sign bit (instr[31]) to XLEN.
REQ-025 pc_sel SHALL be combinational from the registered fields and eq/lt/ltu, and SHALL be 00 when out_valid=0.
REQ-026 Branch pc_sel=01 conditions: BEQ eq; BNE !eq; BLT lt; BGE !lt; BLTU ltu; BGEU !ltu. JAL SHALL give pc_sel=01 and JALR SHALL give pc_sel=10.
REQ-027 Illegal encodings (unknown opcode, bad funct3/funct7, instr[1:0]!=11) SHALL set illegal=1, reg_write=mem_read=mem_write=0, wb_sel=00 and is_branch=is_jal=is_jalr=0.
REQ-028 illegal_cnt SHALL increment by 1 on each transfer of an illegal instruction and SHALL saturate at 2^CNT_W-1.
REQ-029 An illegal instruction that is later flushed SHALL still remain counted.

Reset
REQ-030 While rst=1: out_valid=0, illegal_cnt=0, and all registered out_* fields=0; in_ready=0.
REQ-031 rst SHALL override flush and any transfer; reset mid-transfer SHALL discard the held instruction.

Verification
REQ-032 ADD x3,x1,x2 (0x002081B3) -> next cycle: out_valid=1, rs1=1, rs2=2, rd=3, alu_func=0000, op2_sel=00, wb_sel=01, reg_write=1, illegal=0.
REQ-033 ADDI x1,x0,-1 (0xFFF00093), XLEN=64 -> imm=0xFFFFFFFFFFFFFFFF, op2_sel=01; LUI x5,0x12345 (0x123452B7), XLEN=32 -> imm=0x12345000, alu_func=1010.
REQ-034 BEQ x1,x2,+8 (0x00208463) -> imm=8, is_branch=1; eq=1 -> pc_sel=01; eq=0 -> pc_sel=00.
REQ-035 Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; then out_ready=1 -> next instruction accepted with no loss or duplication.
REQ-036 Instruction 0x00000000 accepted 300 times with CNT_W=8 -> illegal=1, reg_write=0, and illegal_cnt saturates at 255.
REQ-037 flush=1 together with in_valid=1 -> in_ready=0, out_valid=0 next cycle; rst=1 mid-stream -> out_valid=0 and illegal_cnt=0 next cycle.

Source files
------------

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch-side handshake in, decoded-instruction handshake out,
// plus the branch compare flags coming back for the held instruction.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm;
  logic [3:0]      alu_func;
  logic            op1_sel;
  logic [1:0]      op2_sel;
  logic [1:0]      wb_sel;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            illegal;
  logic [2:0]      br_type;
  logic            is_branch;
  logic            is_jal;
  logic            is_jalr;

  logic            eq;
  logic            lt;
  logic            ltu;
  logic [1:0]      pc_sel;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, eq, lt, ltu,
    output in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_func,
           op1_sel, op2_sel, wb_sel, reg_write, mem_read, mem_write,
           illegal, br_type, is_branch, is_jal, is_jalr, pc_sel
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready, eq, lt, ltu,
    input  in_ready, out_valid, out_pc, rs1, rs2, rd, imm, alu_func,
           op1_sel, op2_sel, wb_sel, reg_write, mem_read, mem_write,
           illegal, br_type, is_branch, is_jal, is_jalr, pc_sel
  );
endinterface

// File: rtl/decode_stage.sv
// One-entry registered RV32I decode stage with skid-free valid/ready handshake,
// next-pc select from external compare flags and a saturating illegal counter.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  output logic [CNT_W-1:0]  illegal_cnt,
  decode_stage_if.slave     bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  localparam bit RV64 = (XLEN == 64);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_func;
    logic            op1_sel;
    logic [1:0]      op2_sel;
    logic [1:0]      wb_sel;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic [2:0]      br_type;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
  } dec_t;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  dec_t                   dec_d, dec_q;
  logic                   vld_d, vld_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q;
  logic signed [31:0]     imm32;
  logic                   ill;
  logic                   xfer;
  logic [6:0]             opc;
  logic [2:0]             f3;
  logic [6:0]             f7;
  logic                   shl_ok;
  logic                   shr_ok;

  assign opc = bus.in_instr[6:0];
  assign f3  = bus.in_instr[14:12];
  assign f7  = bus.in_instr[31:25];

  // A 64-bit datapath takes a 6-bit shamt, so bit 25 leaves the funct7 check.
  assign shl_ok = RV64 ? (bus.in_instr[31:26] == 6'b000000)
                       : (f7 == 7'b0000000);
  assign shr_ok = RV64 ? (bus.in_instr[31:26] == 6'b000000 ||
                          bus.in_instr[31:26] == 6'b010000)
                       : (f7 == 7'b0000000 || f7 == 7'b0100000);

  always_comb begin
    dec_d     = '0;
    imm32     = '0;
    ill       = 1'b0;
    dec_d.pc  = bus.in_pc;
    dec_d.rs1 = bus.in_instr[19:15];
    dec_d.rs2 = bus.in_instr[24:20];
    dec_d.rd  = bus.in_instr[11:7];
    case (opc)
      OP_R: begin
        dec_d.alu_func  = alu_of(f3, bus.in_instr[30]);
        dec_d.wb_sel    = 2'b01;
        dec_d.reg_write = 1'b1;
        if (!(f7 == 7'b0000000 ||
              (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))))
          ill = 1'b1;
      end
      OP_IALU: begin
        dec_d.alu_func  = alu_of(f3, (f3 == 3'b101) && bus.in_instr[30]);
        dec_d.op2_sel   = 2'b01;
        dec_d.wb_sel    = 2'b01;
        dec_d.reg_write = 1'b1;
        imm32           = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        if ((f3 == 3'b001 && !shl_ok) || (f3 == 3'b101 && !shr_ok))
          ill = 1'b1;
      end
      OP_LOAD: begin
        dec_d.alu_func  = ALU_ADD;
        dec_d.op2_sel   = 2'b01;
        dec_d.mem_read  = 1'b1;
        dec_d.wb_sel    = 2'b10;
        dec_d.reg_write = 1'b1;
        imm32           = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        if (f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110)))
          ill = 1'b1;
      end
      OP_STORE: begin
        dec_d.alu_func  = ALU_ADD;
        dec_d.op2_sel   = 2'b01;
        dec_d.mem_write = 1'b1;
        imm32           = {{20{bus.in_instr[31]}}, bus.in_instr[31:25],
                           bus.in_instr[11:7]};
        if (f3[2] || (!RV64 && f3 == 3'b011))
          ill = 1'b1;
      end
      OP_BRANCH: begin
        dec_d.alu_func  = ALU_SUB;
        dec_d.is_branch = 1'b1;
        dec_d.br_type   = f3;
        imm32           = {{20{bus.in_instr[31]}}, bus.in_instr[7],
                           bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
        if (f3 == 3'b010 || f3 == 3'b011)
          ill = 1'b1;
      end
      OP_JAL: begin
        dec_d.is_jal    = 1'b1;
        dec_d.wb_sel    = 2'b11;
        dec_d.reg_write = 1'b1;
        imm32           = {{12{bus.in_instr[31]}}, bus.in_instr[19:12],
                           bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      end
      OP_JALR: begin
        dec_d.is_jalr   = 1'b1;
        dec_d.op2_sel   = 2'b01;
        dec_d.wb_sel    = 2'b11;
        dec_d.reg_write = 1'b1;
        imm32           = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
        if (f3 != 3'b000)
          ill = 1'b1;
      end
      OP_LUI: begin
        dec_d.alu_func  = ALU_PASS;
        dec_d.op2_sel   = 2'b01;
        dec_d.wb_sel    = 2'b01;
        dec_d.reg_write = 1'b1;
        imm32           = {bus.in_instr[31:12], 12'h000};
      end
      OP_AUIPC: begin
        dec_d.alu_func  = ALU_ADD;
        dec_d.op1_sel   = 1'b1;
        dec_d.op2_sel   = 2'b01;
        dec_d.wb_sel    = 2'b01;
        dec_d.reg_write = 1'b1;
        imm32           = {bus.in_instr[31:12], 12'h000};
      end
      default: ill = 1'b1;
    endcase
    if (bus.in_instr[1:0] != 2'b11)
      ill = 1'b1;
    // Side-effecting controls are squashed so an illegal op can never retire.
    if (ill) begin
      dec_d.reg_write = 1'b0;
      dec_d.mem_read  = 1'b0;
      dec_d.mem_write = 1'b0;
      dec_d.wb_sel    = 2'b00;
      dec_d.is_branch = 1'b0;
      dec_d.is_jal    = 1'b0;
      dec_d.is_jalr   = 1'b0;
      dec_d.br_type   = 3'b000;
    end
    dec_d.illegal = ill;
    dec_d.imm     = sext32(imm32);
  end

  assign bus.in_ready = (!vld_q || bus.out_ready) && !flush && !rst;
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (flush)
      vld_d = 1'b0;
    else if (xfer)
      vld_d = 1'b1;
    else if (bus.out_ready)
      vld_d = 1'b0;
    if (xfer && dec_d.illegal)
      cnt_d = sat_inc(cnt_q);
  end

  // Stage boundary: decoded fields captured on transfer only, so a stalled
  // output holds without extra enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      cnt_q <= '0;
      dec_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      if (xfer)
        dec_q <= dec_d;
    end
  end

  always_comb begin
    bus.pc_sel = 2'b00;
    if (vld_q) begin
      if (dec_q.is_jalr)
        bus.pc_sel = 2'b10;
      else if (dec_q.is_jal)
        bus.pc_sel = 2'b01;
      else if (dec_q.is_branch) begin
        case (dec_q.br_type)
          3'b000:  bus.pc_sel = {1'b0,  bus.eq};
          3'b001:  bus.pc_sel = {1'b0, !bus.eq};
          3'b100:  bus.pc_sel = {1'b0,  bus.lt};
          3'b101:  bus.pc_sel = {1'b0, !bus.lt};
          3'b110:  bus.pc_sel = {1'b0,  bus.ltu};
          3'b111:  bus.pc_sel = {1'b0, !bus.ltu};
          default: bus.pc_sel = 2'b00;
        endcase
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_pc    = dec_q.pc;
  assign bus.rs1       = dec_q.rs1;
  assign bus.rs2       = dec_q.rs2;
  assign bus.rd        = dec_q.rd;
  assign bus.imm       = dec_q.imm;
  assign bus.alu_func  = dec_q.alu_func;
  assign bus.op1_sel   = dec_q.op1_sel;
  assign bus.op2_sel   = dec_q.op2_sel;
  assign bus.wb_sel    = dec_q.wb_sel;
  assign bus.reg_write = dec_q.reg_write;
  assign bus.mem_read  = dec_q.mem_read;
  assign bus.mem_write = dec_q.mem_write;
  assign bus.illegal   = dec_q.illegal;
  assign bus.br_type   = dec_q.br_type;
  assign bus.is_branch = dec_q.is_branch;
  assign bus.is_jal    = dec_q.is_jal;
  assign bus.is_jalr   = dec_q.is_jalr;
  assign illegal_cnt   = cnt_q;

endmodule
